// File: rtl/bus_cycle_pkg.sv
// Shared 68030 bus-termination types: port-width codes, DSACK encodings and the cycle FSM states.
// Pure declarations, no timing; the port-width codes are shared with the device decode.
package bus_cycle_pkg;

    localparam logic [1:0] PORT_WIDTH_NULL = 2'b00;
    localparam logic [1:0] PORT_WIDTH_BYTE = 2'b01;
    localparam logic [1:0] PORT_WIDTH_WORD = 2'b10;
    localparam logic [1:0] PORT_WIDTH_LONG = 2'b11;

    localparam logic [1:0] DSACK_NONE = 2'b00;
    localparam logic [1:0] DSACK_BYTE = 2'b01;
    localparam logic [1:0] DSACK_WORD = 2'b10;
    localparam logic [1:0] DSACK_LONG = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_BERR,
        ST_DRAIN
    } state_t;

    function automatic logic [1:0] width_to_dsack(input logic [1:0] width);
        case (width)
            PORT_WIDTH_BYTE: return DSACK_BYTE;
            PORT_WIDTH_WORD: return DSACK_WORD;
            PORT_WIDTH_LONG: return DSACK_LONG;
            default:         return DSACK_NONE;
        endcase
    endfunction

endpackage

// File: rtl/wait_state_regs.sv
// Per-device wait-state register file: one write port, one read port selected by a one-hot device vector.
// Writes land on the clock edge; the read is combinational, so a same-edge write is seen only by later reads.
module wait_state_regs
    import bus_cycle_pkg::*;
#(
    parameter int NUM_DEVICES  = 16,
    parameter int WAIT_WIDTH   = 4,
    parameter int DEFAULT_WAIT = 2,
    parameter int IDX_W        = $clog2(NUM_DEVICES)
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   cfg_we_i,
    input  logic [IDX_W-1:0]       cfg_index_i,
    input  logic [WAIT_WIDTH-1:0]  cfg_wait_i,
    input  logic [NUM_DEVICES-1:0] rd_sel_i,
    output logic [WAIT_WIDTH-1:0]  rd_wait_o
);

    logic [WAIT_WIDTH-1:0] regs_q [NUM_DEVICES];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_DEVICES; i++) begin
                regs_q[i] <= WAIT_WIDTH'(DEFAULT_WAIT);
            end
        end else if (cfg_we_i && (32'(cfg_index_i) < NUM_DEVICES)) begin
            regs_q[cfg_index_i] <= cfg_wait_i;
        end
    end

    // One-hot select lets the read collapse to an AND-OR tree.
    always_comb begin
        rd_wait_o = '0;
        for (int i = 0; i < NUM_DEVICES; i++) begin
            rd_wait_o = rd_wait_o | (regs_q[i] & {WAIT_WIDTH{rd_sel_i[i]}});
        end
    end

endmodule

// File: rtl/bus_cycle_timer.sv
// 68030 bus-cycle termination: programmable wait states, device hold and a BERR watchdog driving registered DSACK/AVEC/BERR.
// dsack from E(N+1) for wait N; avec/null-berr from E1; terminations hold until AS is sampled low.
module bus_cycle_timer
    import bus_cycle_pkg::*;
#(
    parameter int NUM_DEVICES    = 16,
    parameter int WAIT_WIDTH     = 4,
    parameter int DEFAULT_WAIT   = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           as,
    input  logic                           function_normal_selected,
    input  logic                           function_int_ack_selected,
    input  logic [NUM_DEVICES-1:0]         device_selected,
    input  logic [1:0]                     port_width,
    input  logic [NUM_DEVICES-1:0]         device_hold,
    input  logic                           cfg_we,
    input  logic [$clog2(NUM_DEVICES)-1:0] cfg_index,
    input  logic [WAIT_WIDTH-1:0]          cfg_wait,
    output logic [1:0]                     dsack,
    output logic                           avec,
    output logic                           berr,
    output logic                           busy
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);

    state_t                 state_q, state_d;
    logic [NUM_DEVICES-1:0] dev_q, dev_d;
    logic [1:0]             width_q, width_d;
    logic                   iack_q, iack_d;
    logic [WAIT_WIDTH-1:0]  wait_ctr_q, wait_ctr_d;
    logic [TO_W-1:0]        timeout_ctr_q, timeout_ctr_d;
    logic [1:0]             dsack_q, dsack_d;
    logic                   avec_q, avec_d;
    logic                   berr_q, berr_d;
    logic [WAIT_WIDTH-1:0]  dev_wait;
    logic                   hold_sel;

    wait_state_regs #(
        .NUM_DEVICES  (NUM_DEVICES),
        .WAIT_WIDTH   (WAIT_WIDTH),
        .DEFAULT_WAIT (DEFAULT_WAIT)
    ) u_regs (
        .clk_i       (clock),
        .rst_n_i     (reset_n),
        .cfg_we_i    (cfg_we),
        .cfg_index_i (cfg_index),
        .cfg_wait_i  (cfg_wait),
        .rd_sel_i    (device_selected),
        .rd_wait_o   (dev_wait)
    );

    assign hold_sel = |(device_hold & dev_q);

    always_comb begin
        state_d       = state_q;
        dev_d         = dev_q;
        width_d       = width_q;
        iack_d        = iack_q;
        wait_ctr_d    = wait_ctr_q;
        timeout_ctr_d = timeout_ctr_q;
        if (state_q != ST_IDLE && state_q != ST_DRAIN && timeout_ctr_q != TO_MAX) begin
            timeout_ctr_d = timeout_ctr_q + TO_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (as) begin
                    dev_d         = device_selected;
                    width_d       = port_width;
                    iack_d        = !function_normal_selected && function_int_ack_selected;
                    wait_ctr_d    = dev_wait;
                    timeout_ctr_d = '0;
                    if (function_normal_selected) begin
                        state_d = (|device_selected) ? ST_WAIT : ST_BERR;
                    end else if (function_int_ack_selected) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_WAIT: begin
                if (!as) begin
                    state_d = ST_IDLE;
                end else if (timeout_ctr_q == TO_LAST) begin
                    state_d = ST_BERR;
                end else if (wait_ctr_q != '0) begin
                    wait_ctr_d = wait_ctr_q - WAIT_WIDTH'(1);
                end else if (!hold_sel) begin
                    state_d = (width_q == PORT_WIDTH_NULL) ? ST_BERR : ST_ACK;
                end
            end
            ST_ACK, ST_BERR, ST_DRAIN: begin
                if (!as) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Terminations entered straight from IDLE surface one edge later, matching a zero-wait cycle.
        dsack_d = DSACK_NONE;
        avec_d  = 1'b0;
        berr_d  = 1'b0;
        if (state_q != ST_IDLE) begin
            case (state_d)
                ST_ACK: begin
                    if (iack_q) begin
                        avec_d = 1'b1;
                    end else begin
                        dsack_d = width_to_dsack(width_q);
                    end
                end
                ST_BERR: berr_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            dev_q         <= '0;
            width_q       <= PORT_WIDTH_NULL;
            iack_q        <= 1'b0;
            wait_ctr_q    <= '0;
            timeout_ctr_q <= '0;
            dsack_q       <= DSACK_NONE;
            avec_q        <= 1'b0;
            berr_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            dev_q         <= dev_d;
            width_q       <= width_d;
            iack_q        <= iack_d;
            wait_ctr_q    <= wait_ctr_d;
            timeout_ctr_q <= timeout_ctr_d;
            dsack_q       <= dsack_d;
            avec_q        <= avec_d;
            berr_q        <= berr_d;
        end
    end

    assign dsack = dsack_q;
    assign avec  = avec_q;
    assign berr  = berr_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bus_cycle_timer.sv
// Directed bench for bus_cycle_timer: each task drives one scenario and checks termination edges against hand-computed values.
module tb_bus_cycle_timer;
    import bus_cycle_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        as = 1'b0;
    logic        fn_norm = 1'b0;
    logic        fn_iack = 1'b0;
    logic [15:0] device_selected = '0;
    logic [1:0]  port_width = '0;
    logic [15:0] device_hold = '0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_index = '0;
    logic [3:0]  cfg_wait = '0;
    logic [1:0]  dsack;
    logic        avec, berr, busy;

    int n_checks = 0;
    int n_fail = 0;

    bus_cycle_timer #(
        .NUM_DEVICES(16), .WAIT_WIDTH(4), .DEFAULT_WAIT(2), .TIMEOUT_CYCLES(255)
    ) dut (
        .clock                     (clock),
        .reset_n                   (reset_n),
        .as                        (as),
        .function_normal_selected  (fn_norm),
        .function_int_ack_selected (fn_iack),
        .device_selected           (device_selected),
        .port_width                (port_width),
        .device_hold               (device_hold),
        .cfg_we                    (cfg_we),
        .cfg_index                 (cfg_index),
        .cfg_wait                  (cfg_wait),
        .dsack                     (dsack),
        .avec                      (avec),
        .berr                      (berr),
        .busy                      (busy)
    );

    initial forever #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Presents a cycle; the edge consumed here is E0.
    task automatic start_cycle(input logic norm, input logic iack, input logic [15:0] dev, input logic [1:0] w);
        as = 1'b1;
        fn_norm = norm;
        fn_iack = iack;
        device_selected = dev;
        port_width = w;
        tick();
    endtask

    task automatic end_cycle();
        as = 1'b0;
        fn_norm = 1'b0;
        fn_iack = 1'b0;
        device_selected = '0;
        port_width = PORT_WIDTH_NULL;
        tick();
    endtask

    task automatic cfg_write(input logic [3:0] idx, input logic [3:0] val);
        cfg_we = 1'b1;
        cfg_index = idx;
        cfg_wait = val;
        tick();
        cfg_we = 1'b0;
    endtask

    // Returns the edge index (relative to E0) at which any termination first shows, or -1 if none within the budget.
    task automatic wait_term(input int max_edges, output int e);
        e = -1;
        for (int k = 0; k <= max_edges; k++) begin
            if (e < 0 && (dsack != 2'b00 || avec || berr)) e = k;
            if (e < 0 && k < max_edges) tick();
        end
    endtask

    task automatic test_reset();
        #7;
        n_checks++; if (dsack !== 2'b00) begin n_fail++; $display("FAIL reset_dsack: got %b want 00", dsack); end
        n_checks++; if (avec !== 1'b0) begin n_fail++; $display("FAIL reset_avec: got %b want 0", avec); end
        n_checks++; if (berr !== 1'b0) begin n_fail++; $display("FAIL reset_berr: got %b want 0", berr); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        #6 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_word_default();
        int e;
        start_cycle(1'b1, 1'b0, 16'h0008, PORT_WIDTH_WORD);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL word_busy_e0: got %b want 1", busy); end
        wait_term(10, e);
        n_checks++; if (e != 3) begin n_fail++; $display("FAIL word_edge: got E%0d want E3", e); end
        n_checks++; if (dsack !== 2'b10) begin n_fail++; $display("FAIL word_dsack: got %b want 10", dsack); end
        tick();
        n_checks++; if (dsack !== 2'b10) begin n_fail++; $display("FAIL word_dsack_hold: got %b want 10", dsack); end
        end_cycle();
        n_checks++; if (dsack !== 2'b00) begin n_fail++; $display("FAIL word_dsack_drop: got %b want 00", dsack); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL word_busy_drop: got %b want 0", busy); end
    endtask

    task automatic test_cfg_wait();
        int e;
        cfg_write(4'd5, 4'd0);
        start_cycle(1'b1, 1'b0, 16'h0020, PORT_WIDTH_LONG);
        wait_term(5, e);
        n_checks++; if (e != 1) begin n_fail++; $display("FAIL wait0_edge: got E%0d want E1", e); end
        n_checks++; if (dsack !== 2'b11) begin n_fail++; $display("FAIL wait0_dsack: got %b want 11", dsack); end
        end_cycle();
        cfg_write(4'd5, 4'd15);
        start_cycle(1'b1, 1'b0, 16'h0020, PORT_WIDTH_BYTE);
        wait_term(20, e);
        n_checks++; if (e != 16) begin n_fail++; $display("FAIL wait15_edge: got E%0d want E16", e); end
        n_checks++; if (dsack !== 2'b01) begin n_fail++; $display("FAIL wait15_dsack: got %b want 01", dsack); end
        end_cycle();
    endtask

    task automatic test_hold();
        int e;
        logic seen;
        seen = 1'b0;
        e = -1;
        device_hold = 16'h0004;
        start_cycle(1'b1, 1'b0, 16'h0004, PORT_WIDTH_WORD);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (dsack != 2'b00) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL hold_early: got dsack during hold, want none"); end
        device_hold = '0;
        for (int k = 21; k <= 30; k++) begin
            tick();
            if (e < 0 && dsack != 2'b00) e = k;
        end
        n_checks++; if (e != 21) begin n_fail++; $display("FAIL hold_edge: got E%0d want E21", e); end
        end_cycle();
    endtask

    task automatic test_timeout();
        int e;
        device_hold = 16'h0004;
        start_cycle(1'b1, 1'b0, 16'h0004, PORT_WIDTH_WORD);
        wait_term(300, e);
        n_checks++; if (e != 255) begin n_fail++; $display("FAIL timeout_edge: got E%0d want E255", e); end
        n_checks++; if (berr !== 1'b1) begin n_fail++; $display("FAIL timeout_berr: got %b want 1", berr); end
        n_checks++; if (dsack !== 2'b00) begin n_fail++; $display("FAIL timeout_dsack: got %b want 00", dsack); end
        device_hold = '0;
        end_cycle();
        n_checks++; if (berr !== 1'b0) begin n_fail++; $display("FAIL timeout_berr_drop: got %b want 0", berr); end
    endtask

    task automatic test_null_device();
        int e;
        start_cycle(1'b1, 1'b0, 16'h0000, PORT_WIDTH_WORD);
        wait_term(5, e);
        n_checks++; if (e != 1) begin n_fail++; $display("FAIL null_edge: got E%0d want E1", e); end
        n_checks++; if (berr !== 1'b1) begin n_fail++; $display("FAIL null_berr: got %b want 1", berr); end
        end_cycle();
    endtask

    task automatic test_int_ack();
        int e;
        start_cycle(1'b0, 1'b1, 16'h0000, PORT_WIDTH_NULL);
        wait_term(5, e);
        n_checks++; if (e != 1) begin n_fail++; $display("FAIL iack_edge: got E%0d want E1", e); end
        n_checks++; if (avec !== 1'b1) begin n_fail++; $display("FAIL iack_avec: got %b want 1", avec); end
        n_checks++; if (dsack !== 2'b00) begin n_fail++; $display("FAIL iack_dsack: got %b want 00", dsack); end
        end_cycle();
        n_checks++; if (avec !== 1'b0) begin n_fail++; $display("FAIL iack_avec_drop: got %b want 0", avec); end
    endtask

    task automatic test_fpu();
        logic seen;
        seen = 1'b0;
        start_cycle(1'b0, 1'b0, 16'h0000, PORT_WIDTH_NULL);
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (dsack != 2'b00 || avec || berr) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL fpu_outputs: got a termination, want none"); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fpu_busy: got %b want 1", busy); end
        end_cycle();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fpu_busy_drop: got %b want 0", busy); end
    endtask

    task automatic test_abort();
        logic seen;
        seen = 1'b0;
        cfg_write(4'd6, 4'd5);
        start_cycle(1'b1, 1'b0, 16'h0040, PORT_WIDTH_WORD);
        as = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got busy %b want 0", busy); end
        for (int k = 0; k < 8; k++) begin
            tick();
            if (dsack != 2'b00 || avec || berr) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_term: got a termination, want none"); end
        end_cycle();
    endtask

    task automatic test_back_to_back_cfg();
        int e;
        cfg_we = 1'b1;
        cfg_index = 4'd4;
        cfg_wait = 4'd7;
        start_cycle(1'b1, 1'b0, 16'h0010, PORT_WIDTH_WORD);
        cfg_we = 1'b0;
        wait_term(12, e);
        n_checks++; if (e != 3) begin n_fail++; $display("FAIL same_edge_old: got E%0d want E3", e); end
        end_cycle();
        start_cycle(1'b1, 1'b0, 16'h0010, PORT_WIDTH_WORD);
        wait_term(12, e);
        n_checks++; if (e != 8) begin n_fail++; $display("FAIL same_edge_new: got E%0d want E8", e); end
        end_cycle();
    endtask

    task automatic test_reset_mid();
        int e;
        start_cycle(1'b1, 1'b0, 16'h0008, PORT_WIDTH_WORD);
        wait_term(10, e);
        n_checks++; if (dsack !== 2'b10) begin n_fail++; $display("FAIL rst_pre_ack: got %b want 10", dsack); end
        #1 reset_n = 1'b0;
        as = 1'b0;
        fn_norm = 1'b0;
        device_selected = '0;
        #1;
        n_checks++; if (dsack !== 2'b00) begin n_fail++; $display("FAIL rst_mid_dsack: got %b want 00", dsack); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        #1 reset_n = 1'b1;
        tick();
        start_cycle(1'b1, 1'b0, 16'h0020, PORT_WIDTH_LONG);
        wait_term(20, e);
        n_checks++; if (e != 3) begin n_fail++; $display("FAIL rst_regs_default: got E%0d want E3", e); end
        n_checks++; if (dsack !== 2'b11) begin n_fail++; $display("FAIL rst_regs_dsack: got %b want 11", dsack); end
        end_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL time_limit: simulation still running at %0t, want finished", $time);
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_word_default();
        test_cfg_wait();
        test_hold();
        test_timeout();
        test_null_device();
        test_int_ack();
        test_fpu();
        test_abort();
        test_back_to_back_cfg();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
